// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and default widths for the frequency-meter stages
//
// Purpose : FSM state enum and default parameter values for freq_duty_calc.
// Ports   : none (package).
package freq_meter_pkg;

  localparam longint unsigned FM_CLK_HZ = 64'd50_000_000;
  localparam int              FM_W      = 32;
  localparam int              FM_DSCALE = 1000;
  localparam int              FM_DW     = $clog2(FM_DSCALE + 1);
  localparam int              FM_NW     = FM_W + FM_DW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIVF = 2'd1,
    DIVD = 2'd2,
    FIN  = 2'd3
  } calc_state_e;

endpackage

// File: rtl/freq_duty_calc_if.sv
// rtl/freq_duty_calc_if.sv - request/result bundle of the frequency/duty converter
//
// Purpose : groups the request strobe, operands and results.
// Signals : start, period, p_time (master -> slave)
//           busy, done, freq, duty, err (slave -> master)
interface freq_duty_calc_if
  import freq_meter_pkg::*;
#(
  parameter int W  = FM_W,
  parameter int DW = FM_DW
);

  logic          start;
  logic [W-1:0]  period;
  logic [W-1:0]  p_time;
  logic          busy;
  logic          done;
  logic [W-1:0]  freq;
  logic [DW-1:0] duty;
  logic          err;

  modport master (output start, period, p_time, input busy, done, freq, duty, err);
  modport slave  (input start, period, p_time, output busy, done, freq, duty, err);

endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring shift-subtract divider, one quotient bit per cycle
//
// Purpose : quot = floor(num / den); remainder is discarded.
// Ports   : clk, rst (async, active-high)
//           load  - capture num/den and start
//           num   - NW-bit dividend, den - DENW-bit divisor
//           busy  - iterating
//           done  - 1-cycle pulse NW cycles after load; quot valid from then
//           quot  - NW-bit quotient
module seq_divider #(
  parameter int NW   = 42,
  parameter int DENW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [NW-1:0]   num,
  input  logic [DENW-1:0] den,
  output logic            busy,
  output logic            done,
  output logic [NW-1:0]   quot
);

  localparam int CW = $clog2(NW + 1);

  logic [NW-1:0]   quot_q, quot_d;
  logic [DENW-1:0] rem_q, rem_d;
  logic [DENW-1:0] den_q, den_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DENW:0]   rem_sh;
  logic [DENW:0]   diff;

  // The quotient register doubles as the dividend shift register: its MSB
  // feeds the partial remainder while quotient bits enter at the LSB.
  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    rem_sh = {rem_q, quot_q[NW-1]};
    diff   = rem_sh - {1'b0, den_q};
    if (load) begin
      quot_d = num;
      rem_d  = '0;
      den_d  = den;
      cnt_d  = CW'(NW);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Borrow out of the top bit means the trial subtract went negative.
      if (!diff[DENW]) begin
        rem_d  = diff[DENW-1:0];
        quot_d = {quot_q[NW-2:0], 1'b1};
      end else begin
        rem_d  = rem_sh[DENW-1:0];
        quot_d = {quot_q[NW-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;

endmodule

// File: rtl/freq_duty_calc.sv
// rtl/freq_duty_calc.sv - period/high-time counts to frequency (Hz) and duty (per-mille)
//
// Purpose : freq = floor(CLK_HZ/period), duty = floor(min(p_time,period)*DSCALE/period)
//           using one shared sequential divider run twice per request.
// Ports   : clk, rst (async, active-high)
//           bus (slave) - start/period/p_time in; busy/done/freq/duty/err out
module freq_duty_calc
  import freq_meter_pkg::*;
#(
  parameter longint unsigned CLK_HZ = FM_CLK_HZ,
  parameter int              W      = FM_W,
  parameter int              DSCALE = FM_DSCALE
) (
  input  logic             clk,
  input  logic             rst,
  freq_duty_calc_if.slave  bus
);

  localparam int DW = $clog2(DSCALE + 1);
  localparam int NW = W + DW;

  if ((CLK_HZ >> W) != 0) begin : g_clk_hz_check
    $error("CLK_HZ does not fit in W bits");
  end

  calc_state_e   state_q, state_d;
  logic [W-1:0]  period_q, period_d;
  logic [W-1:0]  ptime_q, ptime_d;
  logic [W-1:0]  freq_r_q, freq_r_d;
  logic [DW-1:0] duty_r_q, duty_r_d;
  logic [W-1:0]  freq_q, freq_d;
  logic [DW-1:0] duty_q, duty_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          div_load;
  logic [NW-1:0] div_num;
  logic [W-1:0]  div_den;
  logic          div_busy;
  logic          div_done;
  logic [NW-1:0] div_quot;
  logic [W-1:0]  clamp;
  logic [NW-1:0] duty_num;
  logic          quot_unused;

  // High time can never exceed the period, so clamp before scaling; the
  // NW-bit product cannot overflow for any W-bit operand.
  assign clamp    = (ptime_q > period_q) ? period_q : ptime_q;
  assign duty_num = NW'(clamp) * NW'(DSCALE);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    ptime_d  = ptime_q;
    freq_r_d = freq_r_q;
    duty_r_d = duty_r_q;
    freq_d   = freq_q;
    duty_d   = duty_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_num  = '0;
    div_den  = period_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          period_d = bus.period;
          ptime_d  = bus.p_time;
          busy_d   = 1'b1;
          state_d  = DIVF;
          // The first divide starts straight from the live inputs so no
          // cycle is spent waiting for the capture registers.
          if (bus.period != '0) begin
            div_load = 1'b1;
            div_num  = NW'(CLK_HZ);
            div_den  = bus.period;
          end
        end
      end
      DIVF: begin
        // A zero period never started the divider; leave for FIN at once.
        if (period_q == '0) begin
          state_d = FIN;
        end else if (div_done) begin
          freq_r_d = div_quot[W-1:0];
          div_load = 1'b1;
          div_num  = duty_num;
          div_den  = period_q;
          state_d  = DIVD;
        end
      end
      DIVD: begin
        if (div_done) begin
          duty_r_d = div_quot[DW-1:0];
          state_d  = FIN;
        end
      end
      FIN: begin
        if (period_q == '0) begin
          freq_d = '0;
          duty_d = '0;
          err_d  = 1'b1;
        end else begin
          freq_d = freq_r_q;
          duty_d = duty_r_q;
          err_d  = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      ptime_q  <= '0;
      freq_r_q <= '0;
      duty_r_q <= '0;
      freq_q   <= '0;
      duty_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      ptime_q  <= ptime_d;
      freq_r_q <= freq_r_d;
      duty_r_q <= duty_r_d;
      freq_q   <= freq_d;
      duty_q   <= duty_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  seq_divider #(
    .NW   (NW),
    .DENW (W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .load (div_load),
    .num  (div_num),
    .den  (div_den),
    .busy (div_busy),
    .done (div_done),
    .quot (div_quot)
  );

  // Quotients never exceed W bits here; the upper bits are always zero.
  assign quot_unused = ^{div_quot[NW-1:W], div_busy};

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.freq = freq_q;
  assign bus.duty = duty_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_freq_duty_calc.sv
// tb/tb_freq_duty_calc.sv - scoreboard bench for freq_duty_calc
module tb_freq_duty_calc;
  import freq_meter_pkg::*;

  typedef struct {
    logic [31:0] freq;
    logic [9:0]  duty;
    logic        err;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  res_t sb[$];
  res_t last_exp;

  always #5 clk = ~clk;

  freq_duty_calc_if bus ();

  freq_duty_calc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drive one start strobe; push the expected result when one is due.
  task automatic issue(input logic [31:0] p, input logic [31:0] t, input bit expect_res);
    res_t r;
    longint unsigned c;
    bus.period = p;
    bus.p_time = t;
    bus.start  = 1'b1;
    if (p == 32'd0) begin
      r.freq = '0;
      r.duty = '0;
      r.err  = 1'b1;
    end else begin
      c      = (t > p) ? longint'(p) : longint'(t);
      r.freq = 32'(FM_CLK_HZ / longint'(p));
      r.duty = 10'((c * 1000) / longint'(p));
      r.err  = 1'b0;
    end
    if (expect_res) sb.push_back(r);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pop_exp(output res_t e);
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.freq = 'x;
      e.duty = 'x;
      e.err  = 1'bx;
    end
    last_exp = e;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.period = '0;
    bus.p_time = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.freq !== 32'd0 || bus.duty !== 10'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b err=%b freq=%0d duty=%0d exp all 0",
               bus.busy, bus.done, bus.err, bus.freq, bus.duty);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    res_t e;
    int   lat;
    issue(32'd50_000, 32'd12_500, 1'b1);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got=%b exp=1", bus.busy);
    end
    wait_done(200, lat);
    pop_exp(e);
    checks++;
    if (lat !== 87) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=87", lat);
    end
    checks++;
    if (bus.freq !== 32'd1000 || bus.duty !== 10'd250 || bus.err !== 1'b0 ||
        bus.freq !== e.freq || bus.duty !== e.duty) begin
      failures++;
      $display("FAIL basic_result got freq=%0d duty=%0d err=%b exp freq=1000 duty=250 err=0",
               bus.freq, bus.duty, bus.err);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_at_done got=%b exp=0", bus.busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.freq !== e.freq) begin
      failures++;
      $display("FAIL basic_done_pulse got done=%b freq=%0d exp done=0 freq=%0d", bus.done, bus.freq, e.freq);
    end
  endtask

  task automatic test_err();
    res_t e;
    int   lat;
    issue(32'd0, 32'd5, 1'b1);
    wait_done(20, lat);
    pop_exp(e);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL err_latency got=%0d exp=2", lat);
    end
    checks++;
    if (bus.err !== e.err || bus.freq !== e.freq || bus.duty !== e.duty) begin
      failures++;
      $display("FAIL err_result got freq=%0d duty=%0d err=%b exp freq=%0d duty=%0d err=%b",
               bus.freq, bus.duty, bus.err, e.freq, e.duty, e.err);
    end
  endtask

  // Covers the divide-by-3 truncation, duty clamp, p_time==0, period==1,
  // full-width operands, and starts issued the cycle after each done.
  task automatic test_back_to_back();
    logic [31:0] tp[6] = '{32'd3, 32'd100, 32'd1, 32'd7, 32'hFFFF_FFFF, 32'd123_457};
    logic [31:0] tt[6] = '{32'd1, 32'd250, 32'd0, 32'd3, 32'hFFFF_FFFF, 32'd99_999};
    res_t e;
    int   lat;
    for (int k = 0; k < 6; k++) begin
      issue(tp[k], tt[k], 1'b1);
      wait_done(200, lat);
      pop_exp(e);
      checks++;
      if (lat !== 87) begin
        failures++;
        $display("FAIL b2b_latency[%0d] got=%0d exp=87", k, lat);
      end
      checks++;
      if (bus.freq !== e.freq || bus.duty !== e.duty || bus.err !== e.err) begin
        failures++;
        $display("FAIL b2b_result[%0d] got freq=%0d duty=%0d err=%b exp freq=%0d duty=%0d err=%b",
                 k, bus.freq, bus.duty, bus.err, e.freq, e.duty, e.err);
      end
    end
  endtask

  task automatic test_ignore_start();
    res_t prev;
    res_t e;
    int   lat = -1;
    int   ndone = 0;
    prev = last_exp;
    issue(32'd1000, 32'd300, 1'b1);
    for (int i = 1; i <= 150; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
      if (i == 9 || i == 39) begin
        bus.start  = 1'b1;
        bus.period = 32'd7;
        bus.p_time = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      if (i == 60) begin
        checks++;
        if (bus.freq !== prev.freq || bus.duty !== prev.duty || bus.err !== prev.err) begin
          failures++;
          $display("FAIL ignore_hold got freq=%0d duty=%0d exp freq=%0d duty=%0d",
                   bus.freq, bus.duty, prev.freq, prev.duty);
        end
      end
    end
    pop_exp(e);
    checks++;
    if (ndone !== 1 || lat !== 87) begin
      failures++;
      $display("FAIL ignore_done_count got=%0d lat=%0d exp count=1 lat=87", ndone, lat);
    end
    checks++;
    if (bus.freq !== 32'd50_000 || bus.duty !== e.duty || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result got freq=%0d duty=%0d exp freq=50000 duty=%0d",
               bus.freq, bus.duty, e.duty);
    end
  endtask

  task automatic test_reset_abort();
    res_t e;
    int   lat;
    int   ndone = 0;
    issue(32'd5000, 32'd100, 1'b0);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.freq !== 32'd0 || bus.duty !== 10'd0) begin
      failures++;
      $display("FAIL abort_in_reset got busy=%b done=%b err=%b freq=%0d duty=%0d exp all 0",
               bus.busy, bus.done, bus.err, bus.freq, bus.duty);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    checks++;
    if (ndone !== 0 || bus.freq !== 32'd0 || bus.duty !== 10'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_after_reset got dones=%0d freq=%0d duty=%0d busy=%b exp 0",
               ndone, bus.freq, bus.duty, bus.busy);
    end
    issue(32'd2, 32'd1, 1'b1);
    wait_done(200, lat);
    pop_exp(e);
    checks++;
    if (lat !== 87 || bus.freq !== 32'd25_000_000 || bus.duty !== e.duty) begin
      failures++;
      $display("FAIL abort_next got lat=%0d freq=%0d duty=%0d exp lat=87 freq=25000000 duty=%0d",
               lat, bus.freq, bus.duty, e.duty);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
